// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch (I) and
// data access (D), routing each 1-cycle read response back to its requester.
module unified_mem_arbiter #(
    parameter int ALEN         = 32,
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [ALEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [31:0]     i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [ALEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            m_en,
    output logic            m_we,
    output logic [3:0]      m_be,
    output logic [ALEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    input  logic [XLEN-1:0] m_rdata
);

    // Handshake: a requester holds req and its fields stable until the cycle
    // its gnt is high; the access is taken at that edge. Responses (rvalid)
    // come exactly one cycle later and cannot be back-pressured.

    // Keep the counter at least 1 bit wide so STARVE_LIMIT=0 still elaborates.
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic          valid_q;
    logic          wr_q;
    owner_t        owner_q;

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (d_req && !(i_req && (starve_cnt == LIMIT))) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_be    = 4'b0000;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_be    = d_we ? d_be : 4'b0000;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (i_gnt) begin
            m_en   = 1'b1;
            m_addr = i_addr;
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (!i_req || i_gnt) begin
            starve_nxt = '0;
        end else if (starve_cnt != LIMIT) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            valid_q    <= 1'b0;
            wr_q       <= 1'b0;
            owner_q    <= OWN_I;
        end else begin
            starve_cnt <= starve_nxt;
            valid_q    <= i_gnt | d_gnt;
            if (i_gnt || d_gnt) begin
                owner_q <= d_gnt ? OWN_D : OWN_I;
                wr_q    <= d_gnt & d_we;
            end
        end
    end

    // Gating with !rst drops a response whose grant preceded the reset edge.
    assign i_rvalid = !rst && valid_q && (owner_q == OWN_I);
    assign d_rvalid = !rst && valid_q && (owner_q == OWN_D);
    assign i_rdata  = i_rvalid ? m_rdata[31:0] : 32'h0;
    assign d_rdata  = (d_rvalid && !wr_q) ? m_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: behavioural RAM, shadow-memory scoreboard for
// responses, and per-scenario tasks checking grants and memory drive.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram    [256];
    logic [31:0] shadow [256];
    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ALEN(32), .XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Read-first single-port RAM with byte enables.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) ram[m_addr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
            end
            m_rdata <= ram[m_addr[9:2]];
        end
    end

    // Scoreboard: expectation pushed at grant, popped one cycle later.
    always @(negedge clk) begin
        logic        has_i, has_d;
        logic [31:0] ei, ed;
        if (rst) begin
            checks++;
            if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL rvalid_in_reset i_rvalid=%b d_rvalid=%b want 0 0", i_rvalid, d_rvalid);
            end
            i_exp_q.delete();
            d_exp_q.delete();
        end else begin
            has_i = (i_exp_q.size() != 0);
            has_d = (d_exp_q.size() != 0);
            ei = has_i ? i_exp_q.pop_front() : 32'h0;
            ed = has_d ? d_exp_q.pop_front() : 32'h0;
            checks++;
            if (i_rvalid !== has_i) begin
                errors++;
                $display("FAIL sb_i_rvalid got=%b want=%b t=%0t", i_rvalid, has_i, $time);
            end else if (has_i) begin
                checks++;
                if (i_rdata !== ei) begin
                    errors++;
                    $display("FAIL sb_i_rdata got=%h want=%h t=%0t", i_rdata, ei, $time);
                end
            end
            checks++;
            if (d_rvalid !== has_d) begin
                errors++;
                $display("FAIL sb_d_rvalid got=%b want=%b t=%0t", d_rvalid, has_d, $time);
            end else if (has_d) begin
                checks++;
                if (d_rdata !== ed) begin
                    errors++;
                    $display("FAIL sb_d_rdata got=%h want=%h t=%0t", d_rdata, ed, $time);
                end
            end
            if (i_gnt === 1'b1) i_exp_q.push_back(shadow[i_addr[9:2]]);
            if (d_gnt === 1'b1) begin
                if (d_we) begin
                    d_exp_q.push_back(32'h0);
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) shadow[d_addr[9:2]][b*8 +: 8] = d_wdata[b*8 +: 8];
                end else begin
                    d_exp_q.push_back(shadow[d_addr[9:2]]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic set_d_load(input logic [31:0] a);
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = a; d_wdata = 32'h0;
    endtask

    task automatic test_reset();
        i_req = 1'b1; i_addr = 32'h0;
        set_d_load(32'h100);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || m_en !== 1'b0 || m_we !== 1'b0) begin
                errors++;
                $display("FAIL reset_grants i_gnt=%b d_gnt=%b m_en=%b m_we=%b want 0", i_gnt, d_gnt, m_en, m_we);
            end
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_gnt d_gnt=%b i_gnt=%b want 1 0", d_gnt, i_gnt);
        end
        step();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_fetch i_gnt=%b want 1", i_gnt);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_solo_fetch();
        i_req = 1'b1; i_addr = 32'h8;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h8 || m_be !== 4'h0) begin
            errors++;
            $display("FAIL solo_fetch_drive i_gnt=%b d_gnt=%b m_en=%b m_we=%b m_addr=%h m_be=%h want 1 0 1 0 8 0",
                     i_gnt, d_gnt, m_en, m_we, m_addr, m_be);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h00500093 || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL solo_fetch_resp i_rvalid=%b i_rdata=%h d_rvalid=%b d_rdata=%h want 1 00500093 0 0",
                     i_rvalid, i_rdata, d_rvalid, d_rdata);
        end
        checks++;
        if (m_en !== 1'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL idle_mem m_en=%b m_addr=%h m_wdata=%h want 0 0 0", m_en, m_addr, m_wdata);
        end
        step();
    endtask

    task automatic test_conflict();
        set_d_load(32'h100);
        i_req = 1'b1; i_addr = 32'h0;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || m_addr !== 32'h100) begin
            errors++;
            $display("FAIL conflict_gnt d_gnt=%b i_gnt=%b m_addr=%h want 1 0 100", d_gnt, i_gnt, m_addr);
        end
        step();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL conflict_resp d_rvalid=%b d_rdata=%h i_gnt=%b want 1 deadbeef 1", d_rvalid, d_rdata, i_gnt);
        end
        step();
        idle();
        step();
    endtask

    // Both requests held six cycles: D x4, I on cycle 5, D again on 6.
    task automatic run_starve(input string tag);
        set_d_load(32'h100);
        i_req = 1'b1; i_addr = 32'h8;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (d_gnt !== (c != 5) || i_gnt !== (c == 5)) begin
                errors++;
                $display("FAIL %s_cycle%0d d_gnt=%b i_gnt=%b want %b %b", tag, c, d_gnt, i_gnt, c != 5, c == 5);
            end
            if (c == 6) begin
                checks++;
                if (i_rvalid !== 1'b1 || i_rdata !== 32'h00500093) begin
                    errors++;
                    $display("FAIL %s_fetch_resp i_rvalid=%b i_rdata=%h want 1 00500093", tag, i_rvalid, i_rdata);
                end
            end
            step();
            if (c == 5) i_req = 1'b0;
        end
        idle();
        step();
    endtask

    task automatic test_store_then_fetch();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h0C; d_wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || m_we !== 1'b1 || m_be !== 4'hF || m_addr !== 32'h0C || m_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL store_drive d_gnt=%b m_we=%b m_be=%h m_addr=%h m_wdata=%h want 1 1 f c 12345678",
                     d_gnt, m_we, m_be, m_addr, m_wdata);
        end
        step();
        d_req = 1'b0; d_we = 1'b0;
        i_req = 1'b1; i_addr = 32'h0C;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL store_ack d_rvalid=%b d_rdata=%h i_gnt=%b want 1 0 1", d_rvalid, d_rdata, i_gnt);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL fetch_after_store i_rvalid=%b i_rdata=%h want 1 12345678", i_rvalid, i_rdata);
        end
        step();
        // Partial store: only the low half of the word changes.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h0C; d_wdata = 32'hAAAABBBB;
        @(negedge clk);
        checks++;
        if (m_be !== 4'h3) begin
            errors++;
            $display("FAIL partial_store_be m_be=%h want 3", m_be);
        end
        step();
        d_we = 1'b0; d_be = 4'h0;
        @(negedge clk);
        step();
        idle();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234BBBB) begin
            errors++;
            $display("FAIL partial_store_load d_rvalid=%b d_rdata=%h want 1 1234bbbb", d_rvalid, d_rdata);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        i_req = 1'b1; i_addr = 32'h8;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midflight_gnt i_gnt=%b want 1", i_gnt);
        end
        step();
        i_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midflight_dropped i_rvalid=%b want 0", i_rvalid);
        end
        step();
        rst = 1'b0;
        step();
        // Build up denials, reset, and expect the full four-denial window again.
        set_d_load(32'h100);
        i_req = 1'b1; i_addr = 32'h8;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_starve("starve_after_reset");
    endtask

    task automatic test_back_to_back();
        int mc = 0;
        logic exp_i, exp_d;
        idle();
        for (int c = 0; c < 60; c++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1'b1; i_addr = {22'h0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_we = ($urandom_range(0, 1) == 1);
                d_be = 4'($urandom_range(1, 15)); d_wdata = $urandom;
                d_addr = {22'h0, 4'($urandom_range(0, 15)), 2'b00};
            end
            exp_d = d_req && !(i_req && mc == 4);
            exp_i = i_req && !exp_d;
            @(negedge clk);
            checks++;
            if (i_gnt !== exp_i || d_gnt !== exp_d) begin
                errors++;
                $display("FAIL b2b_gnt_c%0d i_gnt=%b d_gnt=%b want %b %b", c, i_gnt, d_gnt, exp_i, exp_d);
            end
            if (!i_req || exp_i) mc = 0;
            else if (mc != 4) mc++;
            step();
            if (exp_i) i_req = 1'b0;
            if (exp_d) begin d_req = 1'b0; d_we = 1'b0; end
        end
        idle();
        step();
        step();
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ram[k] = 32'h01000000 + k;
        ram[0]  = 32'h00000013;
        ram[2]  = 32'h00500093;
        ram[64] = 32'hDEADBEEF;
        for (int k = 0; k < 256; k++) shadow[k] = ram[k];
        #1;
        test_reset();
        test_solo_fetch();
        test_conflict();
        run_starve("starve");
        test_store_then_fetch();
        test_reset_midflight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
